// File: rtl/fifo_cd_arbiter.sv
// Two-producer round-robin write arbiter feeding an 8-entry synchronous FIFO.
// Optional macro FIFO_CD_ARB_SRCTAG_EN stores the winning port with each word and presents it on m_src.
module fifo_cd_arbiter #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s0_valid,
    input  logic [DW-1:0] s0_data,
    output logic          s0_ready,
    input  logic          s1_valid,
    input  logic [DW-1:0] s1_data,
    output logic          s1_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_src,
    input  logic          m_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

`ifdef FIFO_CD_ARB_SRCTAG_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          last_grant_q, last_grant_d;
    logic [MW-1:0] mem_q [DEPTH];

    logic          push0, push1, push, pop;
    logic [MW-1:0] wdata;
    logic [MW-1:0] head;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    // last_grant names the port that won most recently; the other port wins the next contention.
    assign s0_ready = !full && (!s1_valid || last_grant_q);
    assign s1_ready = !full && (!s0_valid || !last_grant_q);

    assign push0 = s0_valid && s0_ready;
    assign push1 = s1_valid && s1_ready;
    assign push  = push0 || push1;
    assign pop   = m_valid && m_ready;

`ifdef FIFO_CD_ARB_SRCTAG_EN
    assign wdata = push1 ? {1'b1, s1_data} : {1'b0, s0_data};
`else
    assign wdata = push1 ? s1_data : s0_data;
`endif

    assign head    = mem_q[rd_ptr_q];
    assign m_valid = !empty;
    assign m_data  = empty ? '0 : head[DW-1:0];
`ifdef FIFO_CD_ARB_SRCTAG_EN
    assign m_src   = empty ? 1'b0 : head[DW];
`else
    assign m_src   = 1'b0;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        if (push) begin
            wr_ptr_d     = wr_ptr_q + AW'(1);
            last_grant_d = push1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
        end
    end

    // NOTE: storage has no reset; count gates m_data/m_src so stale words are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
